hazard_ctrl_mc: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage MIPS core; sits beside the
//  IF/ID/EX/MEM registers and drives their write-enable and flush controls.

---
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl_mc.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-controller inputs and pipeline-control outputs. The pipeline side uses the master modport and the controller uses the slave modport.
// The perf-counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
`timescale 1ns/1ps
interface hazard_ctrl_if #(
    parameter int REG_W   = 5,
    parameter int PCSRC_W = 3
);
    logic               IDEX_MemRead;
    logic [REG_W-1:0]   IDEX_Rt;
    logic [REG_W-1:0]   IFID_Rs;
    logic [REG_W-1:0]   IFID_Rt;
    logic               IFID_RsRead;
    logic               IFID_RtRead;
    logic [PCSRC_W-1:0] ID_PCSrc;
    logic [PCSRC_W-1:0] IDEX_PCSrc;
    logic               EX_need_branch;
    logic               EX_md_start;
    logic               ID_md_use;
    logic               dmem_wait;
    logic               PCWrite;
    logic               IFID_write;
    logic               IFID_flush;
    logic               IDEX_flush;
    logic               PipeFreeze;
    logic               md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]        stall_cycles;
    logic [31:0]        flush_events;
`endif

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_RsRead, IFID_RtRead,
        output ID_PCSrc, IDEX_PCSrc, EX_need_branch, EX_md_start, ID_md_use, dmem_wait,
        input  PCWrite, IFID_write, IFID_flush, IDEX_flush, PipeFreeze, md_busy
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_RsRead, IFID_RtRead,
        input  ID_PCSrc, IDEX_PCSrc, EX_need_branch, EX_md_start, ID_md_use, dmem_wait,
        output PCWrite, IFID_write, IFID_flush, IDEX_flush, PipeFreeze, md_busy
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard controller for the 5-stage MIPS pipeline. It handles load-use stalls, mul/div busy tracking, the dmem freeze, and branch/jump flushes.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles and flush_events counters.
`timescale 1ns/1ps
module hazard_ctrl_mc #(
    parameter int REG_W    = 5,
    parameter int PCSRC_W  = 3,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int CNT_W    = 3
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, LU_STALL} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] lu_cnt_reg, lu_cnt_next;
    logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;

    logic rs_hit, rt_hit, lu_hit, md_busy_int, md_hit, br, jmp, stall;
    logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;

    // $zero and operands the instruction does not read never create a dependency
    assign rs_hit = hz.IFID_RsRead && (hz.IFID_Rs != REG_W'(0)) && (hz.IFID_Rs == hz.IDEX_Rt);
    assign rt_hit = hz.IFID_RtRead && (hz.IFID_Rt != REG_W'(0)) && (hz.IFID_Rt == hz.IDEX_Rt);
    assign lu_hit = hz.IDEX_MemRead && (rs_hit || rt_hit);

    assign md_busy_int = (md_cnt_reg != '0);
    assign md_hit      = hz.ID_md_use && md_busy_int;
    assign br          = (hz.IDEX_PCSrc == PCSRC_W'(4)) && hz.EX_need_branch;
    assign jmp         = (hz.ID_PCSrc == PCSRC_W'(1)) || (hz.ID_PCSrc == PCSRC_W'(2)) ||
                         (hz.ID_PCSrc == PCSRC_W'(3)) || (hz.ID_PCSrc == PCSRC_W'(5));
    assign stall       = (state_reg == LU_STALL) || ((state_reg == RUN) && lu_hit) || md_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= RUN;
            lu_cnt_reg <= '0;
            md_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            lu_cnt_reg <= lu_cnt_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        lu_cnt_next = lu_cnt_reg;
        md_cnt_next = md_cnt_reg;

        // The mul/div unit keeps counting through memory freezes
        if (hz.EX_md_start)
            md_cnt_next = CNT_W'(MD_LAT);
        else if (md_busy_int)
            md_cnt_next = md_cnt_reg - CNT_W'(1);

        if (!hz.dmem_wait) begin
            if (br) begin
                state_next  = RUN;
                lu_cnt_next = '0;
            end else if (state_reg == LU_STALL) begin
                if (lu_cnt_reg <= CNT_W'(1)) begin
                    state_next  = RUN;
                    lu_cnt_next = '0;
                end else begin
                    lu_cnt_next = lu_cnt_reg - CNT_W'(1);
                end
            end else if (lu_hit && (LOAD_LAT > 1)) begin
                state_next  = LU_STALL;
                lu_cnt_next = CNT_W'(LOAD_LAT - 1);
            end
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (!reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hz.dmem_wait) begin
            pipe_freeze = 1'b1;
        end else if (br) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            // A jump sitting in ID is held rather than flushed
            idex_flush = 1'b1;
        end else if (jmp) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    assign hz.PCWrite    = pc_write;
    assign hz.IFID_write = ifid_write;
    assign hz.IFID_flush = ifid_flush;
    assign hz.IDEX_flush = idex_flush;
    assign hz.PipeFreeze = pipe_freeze;
    assign hz.md_busy    = reset && md_busy_int;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_reg, flush_events_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
            flush_events_reg <= '0;
        end else begin
            if (!pc_write && !hz.dmem_wait)
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (ifid_flush || idex_flush)
                flush_events_reg <= flush_events_reg + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles_reg;
    assign hz.flush_events = flush_events_reg;
`endif
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: instance a uses LOAD_LAT=1 and instance b uses LOAD_LAT=3, and both use MD_LAT=4.
// A table of single-cycle vectors runs on a, and hand-written multi-cycle sequences run on b.
`timescale 1ns/1ps
module tb_hazard_ctrl_mc;
    // Output order: {PCWrite, IFID_write, IFID_flush, IDEX_flush, PipeFreeze, md_busy}
    localparam logic [5:0] RUNO = 6'b110000;
    localparam logic [5:0] STL  = 6'b000100;
    localparam logic [5:0] JMPO = 6'b111000;
    localparam logic [5:0] BRO  = 6'b111100;
    localparam logic [5:0] FRZ  = 6'b000010;
    localparam logic [5:0] RSTO = 6'b001100;

    typedef struct packed {
        logic       memread;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsread;
        logic       rtread;
        logic [2:0] id_pc;
        logic [2:0] ex_pc;
        logic       need_br;
        logic       md_start;
        logic       md_use;
        logic       dwait;
        logic [5:0] exp;
    } vec_t;

    typedef struct packed {
        logic        sel;
        logic [5:0]  exp;
        logic [15:0] id;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .PCSRC_W(3)) if_a ();
    hazard_ctrl_if #(.REG_W(5), .PCSRC_W(3)) if_b ();

    hazard_ctrl_mc #(.REG_W(5), .PCSRC_W(3), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(3))
        u_a (.clk(clk), .reset(reset), .hz(if_a));
    hazard_ctrl_mc #(.REG_W(5), .PCSRC_W(3), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(3))
        u_b (.clk(clk), .reset(reset), .hz(if_b));

    logic [5:0] outs_a, outs_b;
    assign outs_a = {if_a.PCWrite, if_a.IFID_write, if_a.IFID_flush, if_a.IDEX_flush, if_a.PipeFreeze, if_a.md_busy};
    assign outs_b = {if_b.PCWrite, if_b.IFID_write, if_b.IFID_flush, if_b.IDEX_flush, if_b.PipeFreeze, if_b.md_busy};

    function automatic vec_t mk(input logic mr, input int irt, input int rs, input int rt,
                                input logic rsr, input logic rtr, input int idpc, input int expc,
                                input logic nb, input logic ms, input logic mu, input logic dw,
                                input logic [5:0] e);
        vec_t v;
        v.memread = mr;       v.idex_rt = 5'(irt);  v.rs = 5'(rs);     v.rt = 5'(rt);
        v.rsread = rsr;       v.rtread = rtr;       v.id_pc = 3'(idpc); v.ex_pc = 3'(expc);
        v.need_br = nb;       v.md_start = ms;      v.md_use = mu;     v.dwait = dw;
        v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic sel, input vec_t v);
        if (!sel) begin
            if_a.IDEX_MemRead = v.memread;  if_a.IDEX_Rt = v.idex_rt;
            if_a.IFID_Rs = v.rs;            if_a.IFID_Rt = v.rt;
            if_a.IFID_RsRead = v.rsread;    if_a.IFID_RtRead = v.rtread;
            if_a.ID_PCSrc = v.id_pc;        if_a.IDEX_PCSrc = v.ex_pc;
            if_a.EX_need_branch = v.need_br; if_a.EX_md_start = v.md_start;
            if_a.ID_md_use = v.md_use;      if_a.dmem_wait = v.dwait;
        end else begin
            if_b.IDEX_MemRead = v.memread;  if_b.IDEX_Rt = v.idex_rt;
            if_b.IFID_Rs = v.rs;            if_b.IFID_Rt = v.rt;
            if_b.IFID_RsRead = v.rsread;    if_b.IFID_RtRead = v.rtread;
            if_b.ID_PCSrc = v.id_pc;        if_b.IDEX_PCSrc = v.ex_pc;
            if_b.EX_need_branch = v.need_br; if_b.EX_md_start = v.md_start;
            if_b.ID_md_use = v.md_use;      if_b.dmem_wait = v.dwait;
        end
    endtask

    task automatic check_out();
        sb_t        e;
        logic [5:0] got;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            got = e.sel ? outs_b : outs_a;
            if (got !== e.exp) begin
                miscompares++;
                $display("FAIL vec%0d dut_%s got=%b exp=%b", e.id, e.sel ? "b" : "a", got, e.exp);
            end else begin
                $display("vec%0d dut_%s ok out=%b", e.id, e.sel ? "b" : "a", got);
            end
        end
    endtask

    // Drive one cycle, check outputs at the falling edge, then move just past the next rising edge
    task automatic step(input logic sel, input vec_t v, input int id);
        drive(sel, v);
        sb.push_back('{sel: sel, exp: v.exp, id: 16'(id)});
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_cnt(input int id);
        vectors++;
        if (if_b.stall_cycles !== 32'd0 || if_b.flush_events !== 32'd0) begin
            miscompares++;
            $display("FAIL perfcnt%0d got stall=%0d flush=%0d exp 0/0", id, if_b.stall_cycles, if_b.flush_events);
        end else begin
            $display("perfcnt%0d ok", id);
        end
    endtask
`endif

    initial begin
        vec_t idle;
        vec_t rst_v;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO);
        rst_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTO);
        drive(1'b0, idle);
        drive(1'b1, idle);

        //           mr irt rs rt rsr rtr idpc expc nb ms mu dw  exp
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL));
        tbl.push_back(mk(0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(1, 9, 3, 9, 1, 1, 0, 0, 0, 0, 0, 0, STL));
        tbl.push_back(mk(1, 9, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(0, 9, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, JMPO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, JMPO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, JMPO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, BRO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, RUNO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, RUNO));
        tbl.push_back(mk(1, 7, 7, 0, 1, 0, 2, 0, 0, 0, 0, 0, STL));
        tbl.push_back(mk(1, 7, 7, 0, 1, 0, 2, 4, 1, 0, 0, 0, BRO));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, FRZ));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, FRZ));
        tbl.push_back(mk(1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, FRZ));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNO));

        @(posedge clk);
        #1;
        step(1'b0, rst_v, 0);
        step(1'b1, rst_v, 1);
        reset = 1'b1;

        foreach (tbl[i]) step(1'b0, tbl[i], 10 + i);
        drive(1'b0, idle);

        // LOAD_LAT=3 with a two-cycle memory freeze mid-stall
        step(1'b1, mk(1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL),  100);
        step(1'b1, mk(0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL),  101);
        step(1'b1, mk(0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, FRZ),  102);
        step(1'b1, mk(0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, FRZ),  103);
        step(1'b1, mk(0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL),  104);
        step(1'b1, mk(0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUNO), 105);

        // Branch resolves while in LU_STALL with a jump in ID
        step(1'b1, mk(1, 5, 5, 0, 1, 0, 2, 0, 0, 0, 0, 0, STL),  110);
        step(1'b1, mk(0, 5, 5, 0, 1, 0, 2, 4, 1, 0, 0, 0, BRO),  111);
        step(1'b1, idle, 112);

        // mul/div busy holds a jump in ID until the counter drains
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUNO), 120);
        for (int k = 0; k < 4; k++)
            step(1'b1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, STL | 6'b000001), 121 + k);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, JMPO), 125);

        // mul/div counter keeps draining through a freeze
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUNO),    130);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000011), 131);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000011), 132);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000101), 133);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000101), 134);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNO),    135);

        // Restart while busy reloads the full latency
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUNO),        140);
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b110001),   141);
        for (int k = 0; k < 4; k++)
            step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 142 + k);
        step(1'b1, idle, 146);

        // Reset in the middle of a load-use stall with mul/div busy
        step(1'b1, mk(1, 4, 4, 0, 1, 0, 0, 0, 0, 1, 0, 0, STL),          150);
        step(1'b1, mk(0, 4, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL | 6'b000001), 151);
        reset = 1'b0;
        step(1'b1, rst_v, 152);
        reset = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
        check_cnt(153);
`endif
        step(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNO), 154);
        step(1'b1, idle, 155);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
